// File: rtl/gpio_ctrl.sv
// gpio_ctrl: memory-mapped GPIO bank controller.
// Holds pad output data/enable state, offers atomic set/clear writes, and
// synchronizes pad inputs to capture enabled rising/falling edges into a
// sticky write-1-to-clear status register that drives a level interrupt.
module gpio_ctrl #(
    parameter int NR_GPIOS    = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset_,
    input  logic                bus_req_valid,
    output logic                bus_req_ready,
    input  logic                bus_req_wr,
    input  logic [4:0]          bus_req_addr,
    input  logic [31:0]         bus_req_wdata,
    output logic                bus_rsp_valid,
    output logic [31:0]         bus_rsp_rdata,
    output logic [NR_GPIOS-1:0] gpio_oe,
    output logic [NR_GPIOS-1:0] gpio_do,
    input  logic [NR_GPIOS-1:0] gpio_di,
    output logic                irq
);

    // Bus handshake states
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RESP = 1'b1;

    // Register word offsets (address bits [4:2])
    localparam logic [2:0] REG_DO      = 3'd0;
    localparam logic [2:0] REG_OE      = 3'd1;
    localparam logic [2:0] REG_DI      = 3'd2;
    localparam logic [2:0] REG_RISE_EN = 3'd3;
    localparam logic [2:0] REG_FALL_EN = 3'd4;
    localparam logic [2:0] REG_STATUS  = 3'd5;
    localparam logic [2:0] REG_DO_SET  = 3'd6;
    localparam logic [2:0] REG_DO_CLR  = 3'd7;

    localparam logic [NR_GPIOS-1:0] GPIO_ZERO = {NR_GPIOS{1'b0}};

    logic [0:0]          state_r;
    logic                ready_r;
    logic                rsp_valid_r;
    logic [31:0]         rdata_r;
    logic [NR_GPIOS-1:0] do_r;
    logic [NR_GPIOS-1:0] oe_r;
    logic [NR_GPIOS-1:0] rise_en_r;
    logic [NR_GPIOS-1:0] fall_en_r;
    logic [NR_GPIOS-1:0] status_r;
    logic [NR_GPIOS-1:0] sync_r [SYNC_STAGES];
    logic [NR_GPIOS-1:0] di_prev_r;
    logic                irq_r;

    logic                accept_s;
    logic [2:0]          reg_sel_s;
    logic [NR_GPIOS-1:0] wmask_s;
    logic [NR_GPIOS-1:0] di_sync_s;
    logic [NR_GPIOS-1:0] do_next_s;
    logic [NR_GPIOS-1:0] oe_next_s;
    logic [NR_GPIOS-1:0] rise_en_next_s;
    logic [NR_GPIOS-1:0] fall_en_next_s;
    logic [NR_GPIOS-1:0] w1c_s;
    logic [NR_GPIOS-1:0] rise_s;
    logic [NR_GPIOS-1:0] fall_s;
    logic [NR_GPIOS-1:0] rd_val_s;
    logic [31:0]         rd_word_s;
    logic                unused_s;

    // Address low bits and data bits above the pin count carry no meaning.
    assign unused_s = ^{bus_req_addr[1:0], bus_req_wdata};

    assign di_sync_s     = sync_r[SYNC_STAGES-1];
    assign bus_req_ready = ready_r;
    assign bus_rsp_valid = rsp_valid_r;
    assign bus_rsp_rdata = rdata_r;
    assign gpio_do       = do_r;
    assign gpio_oe       = oe_r;
    assign irq           = irq_r;

    // Request acceptance and field extraction
    always_comb begin
        accept_s  = bus_req_valid && ready_r;
        reg_sel_s = bus_req_addr[4:2];
        wmask_s   = bus_req_wdata[NR_GPIOS-1:0];
    end

    // Write decode: next register values for an accepted write
    always_comb begin
        do_next_s      = do_r;
        oe_next_s      = oe_r;
        rise_en_next_s = rise_en_r;
        fall_en_next_s = fall_en_r;
        w1c_s          = GPIO_ZERO;
        if (accept_s && bus_req_wr) begin
            case (reg_sel_s)
                REG_DO:      do_next_s      = wmask_s;
                REG_OE:      oe_next_s      = wmask_s;
                REG_RISE_EN: rise_en_next_s = wmask_s;
                REG_FALL_EN: fall_en_next_s = wmask_s;
                REG_STATUS:  w1c_s          = wmask_s;
                REG_DO_SET:  do_next_s      = do_r | wmask_s;
                REG_DO_CLR:  do_next_s      = do_r & ~wmask_s;
                default:     w1c_s          = GPIO_ZERO;
            endcase
        end else begin
            w1c_s = GPIO_ZERO;
        end
    end

    // Read mux, zero-extended to the bus width
    always_comb begin
        rd_val_s = GPIO_ZERO;
        case (reg_sel_s)
            REG_DO:      rd_val_s = do_r;
            REG_OE:      rd_val_s = oe_r;
            REG_DI:      rd_val_s = di_sync_s;
            REG_RISE_EN: rd_val_s = rise_en_r;
            REG_FALL_EN: rd_val_s = fall_en_r;
            REG_STATUS:  rd_val_s = status_r;
            default:     rd_val_s = GPIO_ZERO;
        endcase
        rd_word_s                = 32'd0;
        rd_word_s[NR_GPIOS-1:0]  = rd_val_s;
    end

    // Edge detection on the synchronized inputs, gated by the enables
    always_comb begin
        rise_s = di_sync_s & ~di_prev_r & rise_en_r;
        fall_s = ~di_sync_s & di_prev_r & fall_en_r;
    end

    // Pad input synchronizer chain plus previous-value flop for edge detect
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_r[i] <= GPIO_ZERO;
            end
            di_prev_r <= GPIO_ZERO;
        end else begin
            sync_r[0] <= gpio_di;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
            di_prev_r <= di_sync_s;
        end
    end

    // Bus handshake: one response pulse per accepted request
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_r     <= ST_IDLE;
            ready_r     <= 1'b1;
            rsp_valid_r <= 1'b0;
            rdata_r     <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_r     <= ST_RESP;
                        ready_r     <= 1'b0;
                        rsp_valid_r <= 1'b1;
                        rdata_r     <= bus_req_wr ? 32'd0 : rd_word_s;
                    end else begin
                        rsp_valid_r <= 1'b0;
                        rdata_r     <= 32'd0;
                    end
                end
                ST_RESP: begin
                    state_r     <= ST_IDLE;
                    ready_r     <= 1'b1;
                    rsp_valid_r <= 1'b0;
                    rdata_r     <= 32'd0;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    ready_r     <= 1'b1;
                    rsp_valid_r <= 1'b0;
                    rdata_r     <= 32'd0;
                end
            endcase
        end
    end

    // Control registers, sticky status (new edge beats W1C) and interrupt
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            do_r      <= GPIO_ZERO;
            oe_r      <= GPIO_ZERO;
            rise_en_r <= GPIO_ZERO;
            fall_en_r <= GPIO_ZERO;
            status_r  <= GPIO_ZERO;
            irq_r     <= 1'b0;
        end else begin
            do_r      <= do_next_s;
            oe_r      <= oe_next_s;
            rise_en_r <= rise_en_next_s;
            fall_en_r <= fall_en_next_s;
            status_r  <= (status_r & ~w1c_s) | rise_s | fall_s;
            irq_r     <= |status_r;
        end
    end

endmodule

// File: tb/tb_gpio_ctrl.sv
// Self-checking bench for gpio_ctrl: directed scenarios plus randomized
// register and edge traffic checked against a register-level model.
module tb_gpio_ctrl;

    logic        clk = 1'b0;
    logic        reset_;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic        bus_req_wr;
    logic [4:0]  bus_req_addr;
    logic [31:0] bus_req_wdata;
    logic        bus_rsp_valid;
    logic [31:0] bus_rsp_rdata;
    logic [7:0]  gpio_oe;
    logic [7:0]  gpio_do;
    logic [7:0]  gpio_di;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    // Register-level model state
    logic [7:0] do_m, oe_m, ren_m, fen_m, st_m, di_m;

    gpio_ctrl #(.NR_GPIOS(8), .SYNC_STAGES(2)) dut (
        .clk           (clk),
        .reset_        (reset_),
        .bus_req_valid (bus_req_valid),
        .bus_req_ready (bus_req_ready),
        .bus_req_wr    (bus_req_wr),
        .bus_req_addr  (bus_req_addr),
        .bus_req_wdata (bus_req_wdata),
        .bus_rsp_valid (bus_rsp_valid),
        .bus_rsp_rdata (bus_rsp_rdata),
        .gpio_oe       (gpio_oe),
        .gpio_do       (gpio_do),
        .gpio_di       (gpio_di),
        .irq           (irq)
    );

    always #5 clk = ~clk;

    // One bus transaction; ends two negedges after acceptance
    task automatic bus_op(input logic wr, input logic [2:0] idx, input logic [31:0] wd,
                          output logic [31:0] rd);
        int waitc;
        rd = 32'h0;
        @(negedge clk);
        bus_req_valid = 1'b1;
        bus_req_wr    = wr;
        bus_req_addr  = {idx, 2'b00};
        bus_req_wdata = wd;
        waitc = 0;
        while (bus_req_ready !== 1'b1 && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        if (bus_req_ready !== 1'b1) begin
            checks++; failures++;
            $display("FAIL bus_ready_timeout: ready=%b required 1", bus_req_ready);
            bus_req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        bus_req_valid = 1'b0;
        bus_req_wr    = 1'b0;
        @(negedge clk);
        checks++;
        if (bus_rsp_valid !== 1'b1 || bus_req_ready !== 1'b0) begin
            failures++;
            $display("FAIL rsp_cycle idx=%0d: rsp_valid=%b ready=%b required 1/0",
                     idx, bus_rsp_valid, bus_req_ready);
        end
        rd = bus_rsp_rdata;
        @(negedge clk);
        checks++;
        if (bus_rsp_valid !== 1'b0 || bus_req_ready !== 1'b1) begin
            failures++;
            $display("FAIL rsp_one_cycle idx=%0d: rsp_valid=%b ready=%b required 0/1",
                     idx, bus_rsp_valid, bus_req_ready);
        end
    endtask

    task automatic wr_reg(input logic [2:0] idx, input logic [31:0] wd);
        logic [31:0] dummy;
        bus_op(1'b1, idx, wd, dummy);
    endtask

    task automatic rd_reg(input logic [2:0] idx, output logic [31:0] rd);
        bus_op(1'b0, idx, 32'h0, rd);
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        reset_ = 1'b0;
        bus_req_valid = 1'b0; bus_req_wr = 1'b0;
        bus_req_addr = 5'd0; bus_req_wdata = 32'd0;
        gpio_di = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        if (bus_req_ready !== 1'b1 || bus_rsp_valid !== 1'b0 || bus_rsp_rdata !== 32'h0 ||
            gpio_oe !== 8'h00 || gpio_do !== 8'h00 || irq !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: ready=%b rsp=%b rdata=%h oe=%h do=%h irq=%b required 1/0/0/0/0/0",
                     bus_req_ready, bus_rsp_valid, bus_rsp_rdata, gpio_oe, gpio_do, irq);
        end
        reset_ = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rd_reg(i[2:0], rd);
            checks++;
            if (rd !== 32'h0) begin
                failures++;
                $display("FAIL reset_read idx=%0d: got %h required 00000000", i, rd);
            end
        end
        checks++;
        if (gpio_oe !== 8'h00 || gpio_do !== 8'h00 || irq !== 1'b0) begin
            failures++;
            $display("FAIL reset_pins: oe=%h do=%h irq=%b required 00/00/0", gpio_oe, gpio_do, irq);
        end
        do_m = 8'h00; oe_m = 8'h00; ren_m = 8'h00; fen_m = 8'h00; st_m = 8'h00; di_m = 8'h00;
    endtask

    task automatic test_set_clr();
        wr_reg(3'd0, 32'h0000_00A5);
        checks++;
        if (gpio_do !== 8'hA5) begin failures++; $display("FAIL do_write: got %h required a5", gpio_do); end
        wr_reg(3'd1, 32'h0000_00FF);
        checks++;
        if (gpio_oe !== 8'hFF) begin failures++; $display("FAIL oe_write: got %h required ff", gpio_oe); end
        wr_reg(3'd6, 32'h0000_000A);
        checks++;
        if (gpio_do !== 8'hAF) begin failures++; $display("FAIL do_set: got %h required af", gpio_do); end
        wr_reg(3'd7, 32'h0000_0081);
        checks++;
        if (gpio_do !== 8'h2E) begin failures++; $display("FAIL do_clr: got %h required 2e", gpio_do); end
        do_m = 8'h2E; oe_m = 8'hFF;
    endtask

    task automatic test_di_sync();
        logic [31:0] rd;
        gpio_di = 8'h3C;
        rd_reg(3'd2, rd);
        checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL di_early: got %h required 00000000", rd); end
        rd_reg(3'd2, rd);
        checks++;
        if (rd !== 32'h3C) begin failures++; $display("FAIL di_late: got %h required 0000003c", rd); end
        di_m = 8'h3C;
    endtask

    task automatic test_edges();
        logic [31:0] rd;
        gpio_di = 8'h80;
        repeat (6) @(negedge clk);
        wr_reg(3'd3, 32'h01);
        wr_reg(3'd4, 32'h80);
        rd_reg(3'd5, rd);
        checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL enable_not_retro: got %h required 0", rd); end
        gpio_di = 8'h01;
        repeat (6) @(negedge clk);
        rd_reg(3'd5, rd);
        checks++;
        if (rd !== 32'h81 || irq !== 1'b1) begin
            failures++; $display("FAIL edge_status: got %h irq=%b required 81/1", rd, irq);
        end
        wr_reg(3'd5, 32'h01);
        rd_reg(3'd5, rd);
        checks++;
        if (rd !== 32'h80 || irq !== 1'b1) begin
            failures++; $display("FAIL w1c_partial: got %h irq=%b required 80/1", rd, irq);
        end
        wr_reg(3'd5, 32'h80);
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL irq_clear: got %b required 0", irq); end
        rd_reg(3'd5, rd);
        checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL w1c_all: got %h required 0", rd); end
        di_m = 8'h01; ren_m = 8'h01; fen_m = 8'h80;
    endtask

    task automatic test_w1c_collision();
        logic [31:0] rd;
        gpio_di = 8'h00;
        repeat (6) @(negedge clk);
        @(negedge clk);
        gpio_di = 8'h01;
        @(negedge clk);
        @(negedge clk);
        bus_req_valid = 1'b1; bus_req_wr = 1'b1;
        bus_req_addr = {3'd5, 2'b00}; bus_req_wdata = 32'h01;
        checks++;
        if (bus_req_ready !== 1'b1) begin failures++; $display("FAIL collide_ready: got %b required 1", bus_req_ready); end
        @(posedge clk);
        #1;
        bus_req_valid = 1'b0; bus_req_wr = 1'b0;
        repeat (3) @(negedge clk);
        rd_reg(3'd5, rd);
        checks++;
        if (rd !== 32'h01 || irq !== 1'b1) begin
            failures++; $display("FAIL edge_beats_w1c: got %h irq=%b required 01/1", rd, irq);
        end
        wr_reg(3'd5, 32'hFF);
        di_m = 8'h01;
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        bus_req_valid = 1'b1; bus_req_wr = 1'b1;
        bus_req_addr = {3'd0, 2'b00}; bus_req_wdata = 32'h11;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus_rsp_valid !== 1'b1 || bus_req_ready !== 1'b0 || gpio_do !== 8'h11) begin
            failures++;
            $display("FAIL b2b_first: rsp=%b ready=%b do=%h required 1/0/11", bus_rsp_valid, bus_req_ready, gpio_do);
        end
        bus_req_addr = {3'd6, 2'b00}; bus_req_wdata = 32'h22;
        @(negedge clk);
        checks++;
        if (bus_rsp_valid !== 1'b0 || bus_req_ready !== 1'b1 || gpio_do !== 8'h11) begin
            failures++;
            $display("FAIL b2b_gap: rsp=%b ready=%b do=%h required 0/1/11", bus_rsp_valid, bus_req_ready, gpio_do);
        end
        @(negedge clk);
        checks++;
        if (bus_rsp_valid !== 1'b1 || gpio_do !== 8'h33) begin
            failures++; $display("FAIL b2b_second: rsp=%b do=%h required 1/33", bus_rsp_valid, gpio_do);
        end
        bus_req_valid = 1'b0; bus_req_wr = 1'b0;
        @(negedge clk);
        do_m = 8'h33;
    endtask

    task automatic test_random_regs();
        logic [31:0] rd, wd, exp;
        logic [2:0]  idx;
        logic        wr;
        wr_reg(3'd3, 32'h0);
        wr_reg(3'd4, 32'h0);
        ren_m = 8'h00; fen_m = 8'h00;
        di_m = 8'($urandom);
        gpio_di = di_m;
        repeat (6) @(negedge clk);
        wr_reg(3'd5, 32'hFF);
        st_m = 8'h00;
        for (int n = 0; n < 40; n++) begin
            idx = 3'($urandom_range(7));
            wr  = 1'($urandom_range(1));
            wd  = $urandom;
            if (wr) begin
                wr_reg(idx, wd);
                case (idx)
                    3'd0: do_m = wd[7:0];
                    3'd1: oe_m = wd[7:0];
                    3'd3: ren_m = wd[7:0];
                    3'd4: fen_m = wd[7:0];
                    3'd5: st_m = st_m & ~wd[7:0];
                    3'd6: do_m = do_m | wd[7:0];
                    3'd7: do_m = do_m & ~wd[7:0];
                    default: ;
                endcase
                checks++;
                if (gpio_do !== do_m || gpio_oe !== oe_m) begin
                    failures++;
                    $display("FAIL rand_pins n=%0d idx=%0d: do=%h oe=%h required %h/%h",
                             n, idx, gpio_do, gpio_oe, do_m, oe_m);
                end
            end else begin
                rd_reg(idx, rd);
                case (idx)
                    3'd0: exp = {24'h0, do_m};
                    3'd1: exp = {24'h0, oe_m};
                    3'd2: exp = {24'h0, di_m};
                    3'd3: exp = {24'h0, ren_m};
                    3'd4: exp = {24'h0, fen_m};
                    3'd5: exp = {24'h0, st_m};
                    default: exp = 32'h0;
                endcase
                checks++;
                if (rd !== exp) begin
                    failures++;
                    $display("FAIL rand_read n=%0d idx=%0d: got %h required %h", n, idx, rd, exp);
                end
            end
        end
    endtask

    task automatic test_random_edges();
        logic [31:0] rd;
        logic [7:0]  nv, exp;
        for (int n = 0; n < 8; n++) begin
            ren_m = 8'($urandom);
            fen_m = 8'($urandom);
            wr_reg(3'd3, {24'h0, ren_m});
            wr_reg(3'd4, {24'h0, fen_m});
            wr_reg(3'd5, 32'hFF);
            nv = 8'($urandom);
            gpio_di = nv;
            repeat (6) @(negedge clk);
            exp = (nv & ~di_m & ren_m) | (~nv & di_m & fen_m);
            rd_reg(3'd5, rd);
            checks++;
            if (rd !== {24'h0, exp} || irq !== (exp != 8'h00)) begin
                failures++;
                $display("FAIL rand_edges n=%0d: status=%h irq=%b required %h/%b",
                         n, rd, irq, exp, (exp != 8'h00));
            end
            di_m = nv;
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        wr_reg(3'd0, 32'hFF);
        checks++;
        if (gpio_do !== 8'hFF) begin failures++; $display("FAIL mid_setup: do=%h required ff", gpio_do); end
        @(negedge clk);
        bus_req_valid = 1'b1; bus_req_wr = 1'b0; bus_req_addr = {3'd0, 2'b00};
        @(posedge clk);
        #1;
        bus_req_valid = 1'b0;
        checks++;
        if (bus_rsp_valid !== 1'b1) begin failures++; $display("FAIL mid_in_resp: rsp=%b required 1", bus_rsp_valid); end
        #1;
        reset_ = 1'b0;
        #1;
        checks++;
        if (bus_rsp_valid !== 1'b0 || gpio_do !== 8'h00 || bus_req_ready !== 1'b1) begin
            failures++;
            $display("FAIL mid_abort: rsp=%b do=%h ready=%b required 0/00/1", bus_rsp_valid, gpio_do, bus_req_ready);
        end
        @(negedge clk);
        reset_ = 1'b1;
        @(negedge clk);
        checks++;
        if (bus_req_ready !== 1'b1 || bus_rsp_valid !== 1'b0) begin
            failures++; $display("FAIL mid_release: ready=%b rsp=%b required 1/0", bus_req_ready, bus_rsp_valid);
        end
        rd_reg(3'd0, rd);
        checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL mid_do_read: got %h required 0", rd); end
    endtask

    initial begin
        test_reset();
        test_set_clr();
        test_di_sync();
        test_edges();
        test_w1c_collision();
        test_back_to_back();
        test_random_regs();
        test_random_edges();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
